// File: rtl/pipeline_hazard_sequencer_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
//   pipe_state_t : sequencer state (RUN, MEM_WAIT)
//   XZR          : register index of the zero register; it never carries a real load result
//   REG_W_DEF    : default register-index width
//   CNT_W_DEF    : default performance-counter width
package pipeline_hazard_sequencer_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } pipe_state_t;

  localparam int XZR       = 31;
  localparam int REG_W_DEF = 5;
  localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/pipeline_hazard_sequencer_if.sv
// Hazard-sequencer bus: hazard inputs from the pipeline stages and the
// per-register control outputs back to them.
//   master : sequencer side (hazard info in, stage controls + perf counters out)
//   slave  : pipeline side (hazard info out, stage controls in)
// Parameters: REG_W register-index width, CNT_W perf counter width.
interface pipeline_hazard_sequencer_if
  import pipeline_hazard_sequencer_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic [REG_W-1:0] id_rn;
  logic [REG_W-1:0] id_rm;
  logic             id_uses_rm;
  logic             ex_memRead;
  logic [REG_W-1:0] ex_rd;
  logic             ex_br_taken;
  logic             mem_access;
  logic             dmem_ack;

  logic             dmem_req;
  logic             pc_we;
  logic             pc_sel_br;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_we;
  logic             idex_bubble;
  logic             exmem_we;
  logic             memwb_we;

  logic [CNT_W-1:0] perf_stall;
  logic [CNT_W-1:0] perf_flush;
  logic [CNT_W-1:0] perf_wait;

  modport master (
    input  id_rn, id_rm, id_uses_rm, ex_memRead, ex_rd, ex_br_taken, mem_access, dmem_ack,
    output dmem_req, pc_we, pc_sel_br, ifid_we, ifid_flush, idex_we, idex_bubble,
           exmem_we, memwb_we, perf_stall, perf_flush, perf_wait
  );

  modport slave (
    output id_rn, id_rm, id_uses_rm, ex_memRead, ex_rd, ex_br_taken, mem_access, dmem_ack,
    input  dmem_req, pc_we, pc_sel_br, ifid_we, ifid_flush, idex_we, idex_bubble,
           exmem_we, memwb_we, perf_stall, perf_flush, perf_wait
  );

endinterface

// File: rtl/pipeline_hazard_sequencer_perf_counter.sv
// Saturating event counter used for the sequencer's performance statistics.
// Only compiled when PIPE_PERF_CNT_EN is defined, so the default build has
// no counter flops at all.
// Ports:
//   clk   : counter clock
//   rst_n : asynchronous active-low clear
//   inc   : count one event this cycle
//   count : current value, sticks at all-ones
`ifdef PIPE_PERF_CNT_EN
module pipe_perf_counter
  import pipeline_hazard_sequencer_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Event count register, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {W{1'b0}};
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule
`endif

// File: rtl/pipeline_hazard_sequencer.sv
// Central stall/flush/freeze sequencer for the 5-stage pipeline.
//   - load-use hazard (LDUR in EX feeding ID) -> one-cycle stall with ID/EX bubble
//   - taken branch resolved in EX             -> redirect PC, flush IF/ID, bubble ID/EX,
//                                                then flush IMEM_LAT more wrong-path fetches
//   - data-memory access awaiting ack         -> whole pipeline frozen
// Priority: freeze > branch > pending flush > load-use.
// Ports:
//   clk   : pipeline clock
//   rst_n : asynchronous active-low reset
//   bus   : hazard inputs / stage controls (pipeline_hazard_sequencer_if.master)
// Configuration macro: PIPE_PERF_CNT_EN adds saturating stall/flush/wait
// counters; without it the perf outputs are tied to zero.
module pipeline_hazard_sequencer
  import pipeline_hazard_sequencer_pkg::*;
#(
  parameter int REG_W    = REG_W_DEF,
  parameter int IMEM_LAT = 1,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  pipeline_hazard_sequencer_if.master        bus
);

  localparam logic [1:0]       FLUSH_LAT = 2'(IMEM_LAT);
  localparam logic [REG_W-1:0] ZERO_REG  = REG_W'(XZR);

  pipe_state_t stateR;
  pipe_state_t stateNext;
  logic [1:0]  flushCntR;
  logic [1:0]  flushCntNext;

  logic loadUseS;
  logic freezeS;
  logic stallS;
  logic flushS;

  logic dmemReqS;
  logic pcWeS;
  logic pcSelBrS;
  logic ifidWeS;
  logic ifidFlushS;
  logic idexWeS;
  logic idexBubbleS;
  logic exmemWeS;
  logic memwbWeS;

  // A load into XZR produces nothing to forward, so it can never stall ID.
  assign loadUseS = bus.ex_memRead && (bus.ex_rd != ZERO_REG) &&
                    ((bus.ex_rd == bus.id_rn) ||
                     (bus.id_uses_rm && (bus.ex_rd == bus.id_rm)));

  // State and wrong-path flush counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR    <= RUN;
      flushCntR <= 2'd0;
    end else begin
      stateR    <= stateNext;
      flushCntR <= flushCntNext;
    end
  end

  // Next-state and stage-control decode
  always_comb begin
    stateNext    = stateR;
    flushCntNext = flushCntR;
    dmemReqS     = 1'b0;
    pcWeS        = 1'b0;
    pcSelBrS     = 1'b0;
    ifidWeS      = 1'b0;
    ifidFlushS   = 1'b0;
    idexWeS      = 1'b0;
    idexBubbleS  = 1'b0;
    exmemWeS     = 1'b0;
    memwbWeS     = 1'b0;
    freezeS      = 1'b0;
    stallS       = 1'b0;
    flushS       = 1'b0;

    if (!rst_n) begin
      // While in reset the pipeline registers hold NOP/bubble and nothing advances.
      ifidFlushS  = 1'b1;
      idexBubbleS = 1'b1;
    end else begin
      // The ack cycle out of MEM_WAIT is handled exactly like a RUN cycle with
      // the access completing, so held branches/flushes/stalls resume there.
      case (stateR)
        RUN: begin
          dmemReqS = bus.mem_access;
          freezeS  = bus.mem_access && !bus.dmem_ack;
        end
        MEM_WAIT: begin
          dmemReqS = 1'b1;
          freezeS  = !bus.dmem_ack;
        end
        default: begin
          dmemReqS = 1'b0;
          freezeS  = 1'b0;
        end
      endcase

      if (freezeS) begin
        // Full freeze: every register holds, flush counter holds.
        stateNext = MEM_WAIT;
      end else begin
        stateNext = RUN;
        pcWeS     = 1'b1;
        ifidWeS   = 1'b1;
        idexWeS   = 1'b1;
        exmemWeS  = 1'b1;
        memwbWeS  = 1'b1;
        if (bus.ex_br_taken) begin
          // Branch beats load-use: the stalled ID instruction is wrong-path anyway.
          pcSelBrS     = 1'b1;
          ifidFlushS   = 1'b1;
          idexBubbleS  = 1'b1;
          flushCntNext = FLUSH_LAT;
          flushS       = 1'b1;
        end else if (flushCntR != 2'd0) begin
          ifidFlushS   = 1'b1;
          flushCntNext = flushCntR - 2'd1;
          flushS       = 1'b1;
        end else if (loadUseS) begin
          pcWeS       = 1'b0;
          ifidWeS     = 1'b0;
          idexBubbleS = 1'b1;
          stallS      = 1'b1;
        end else begin
          flushCntNext = flushCntR;
        end
      end
    end
  end

  assign bus.dmem_req    = dmemReqS;
  assign bus.pc_we       = pcWeS;
  assign bus.pc_sel_br   = pcSelBrS;
  assign bus.ifid_we     = ifidWeS;
  assign bus.ifid_flush  = ifidFlushS;
  assign bus.idex_we     = idexWeS;
  assign bus.idex_bubble = idexBubbleS;
  assign bus.exmem_we    = exmemWeS;
  assign bus.memwb_we    = memwbWeS;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] perfStallS;
  logic [CNT_W-1:0] perfFlushS;
  logic [CNT_W-1:0] perfWaitS;

  pipe_perf_counter #(.W(CNT_W)) uStallCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stallS),
    .count (perfStallS)
  );

  pipe_perf_counter #(.W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flushS),
    .count (perfFlushS)
  );

  pipe_perf_counter #(.W(CNT_W)) uWaitCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (freezeS),
    .count (perfWaitS)
  );

  assign bus.perf_stall = perfStallS;
  assign bus.perf_flush = perfFlushS;
  assign bus.perf_wait  = perfWaitS;
`else
  logic unusedPerf;
  assign unusedPerf     = stallS ^ flushS;
  assign bus.perf_stall = {CNT_W{1'b0}};
  assign bus.perf_flush = {CNT_W{1'b0}};
  assign bus.perf_wait  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Scoreboard bench for pipeline_hazard_sequencer: a stimulus process drives
// directed and random hazard patterns and pushes the expected controls
// (from a pipeline-level reference model) into a queue; a monitor process
// samples the DUT mid-cycle and compares against the queue.
module tb_pipeline_hazard_sequencer;

  localparam int REG_W    = 5;
  localparam int IMEM_LAT = 1;
  localparam int CNT_W    = 32;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  // Control vector order: {dmem_req, pc_we, pc_sel_br, ifid_we, ifid_flush,
  //                        idex_we, idex_bubble, exmem_we, memwb_we}
  localparam logic [8:0] V_RESET  = 9'b0_0_0_0_1_0_1_0_0;
  localparam logic [8:0] V_FREEZE = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] V_BRANCH = 9'b0_1_1_1_1_1_1_1_1;
  localparam logic [8:0] V_FLUSH  = 9'b0_1_0_1_1_1_0_1_1;
  localparam logic [8:0] V_STALL  = 9'b0_0_0_0_0_1_1_1_1;
  localparam logic [8:0] V_NORMAL = 9'b0_1_0_1_0_1_0_1_1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_hazard_sequencer_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  pipeline_hazard_sequencer #(
    .REG_W    (REG_W),
    .IMEM_LAT (IMEM_LAT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [8:0]       ctrl;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
    logic [CNT_W-1:0] waitc;
    int               cyc;
  } exp_t;

  exp_t sbQ[$];
  int   nCompared = 0;
  int   nMismatch = 0;
  int   cycleNo   = 0;

  // Reference model: a memory access still outstanding, wrong-path fetches
  // still to discard, and running event totals.
  bit     memPending = 1'b0;
  int     wrongLeft  = 0;
  longint cStall = 0, cFlush = 0, cWait = 0;

  // One clock of stimulus; expectations for this cycle go to the scoreboard.
  task automatic drive(input bit rstA, input logic [4:0] rn, input logic [4:0] rm,
                       input bit usesRm, input bit memRead, input logic [4:0] rd,
                       input bit br, input bit memAcc, input bit ack);
    exp_t       e;
    logic [8:0] v;
    bit         lu, req, frozen;
    @(posedge clk);
    #1;
    rst_n           = ~rstA;
    bus.id_rn       = rn;
    bus.id_rm       = rm;
    bus.id_uses_rm  = usesRm;
    bus.ex_memRead  = memRead;
    bus.ex_rd       = rd;
    bus.ex_br_taken = br;
    bus.mem_access  = memAcc;
    bus.dmem_ack    = ack;
    cycleNo++;
    e.cyc = cycleNo;
    if (rstA) begin
      memPending = 1'b0;
      wrongLeft  = 0;
      cStall = 0; cFlush = 0; cWait = 0;
      e.ctrl = V_RESET;
      e.stall = '0; e.flush = '0; e.waitc = '0;
    end else begin
      e.stall = CNT_W'(cStall);
      e.flush = CNT_W'(cFlush);
      e.waitc = CNT_W'(cWait);
      lu     = memRead && (rd != 5'd31) && (rd == rn || (usesRm && rd == rm));
      req    = memPending || memAcc;
      frozen = req && !ack;
      if (frozen) begin
        v = V_FREEZE;
        if (PERF_EN) cWait++;
      end else if (br) begin
        v = V_BRANCH;
        wrongLeft = IMEM_LAT;
        if (PERF_EN) cFlush++;
      end else if (wrongLeft > 0) begin
        v = V_FLUSH;
        wrongLeft--;
        if (PERF_EN) cFlush++;
      end else if (lu) begin
        v = V_STALL;
        if (PERF_EN) cStall++;
      end else begin
        v = V_NORMAL;
      end
      v[8]       = req;
      memPending = frozen;
      e.ctrl     = v;
    end
    sbQ.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [4:0] randReg();
    int r;
    r = $urandom_range(0, 9);
    return (r >= 8) ? 5'd31 : 5'(r % 4);
  endfunction

  // Monitor: compare DUT outputs mid-cycle against the scoreboard
  initial begin
    exp_t       e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      if (sbQ.size() > 0) begin
        e   = sbQ.pop_front();
        act = {bus.dmem_req, bus.pc_we, bus.pc_sel_br, bus.ifid_we, bus.ifid_flush,
               bus.idex_we, bus.idex_bubble, bus.exmem_we, bus.memwb_we};
        nCompared++;
        if (act !== e.ctrl) begin
          nMismatch++;
          $display("FAIL ctrl cycle %0d: got %b expected %b", e.cyc, act, e.ctrl);
        end
        nCompared++;
        if ({bus.perf_stall, bus.perf_flush, bus.perf_wait} !== {e.stall, e.flush, e.waitc}) begin
          nMismatch++;
          $display("FAIL perf cycle %0d: got %0d/%0d/%0d expected %0d/%0d/%0d", e.cyc,
                   bus.perf_stall, bus.perf_flush, bus.perf_wait, e.stall, e.flush, e.waitc);
        end
      end
    end
  end

  // Stimulus: reset, directed scenarios, then randomized traffic
  initial begin
    rst_n = 1'b0;
    bus.id_rn = '0; bus.id_rm = '0; bus.id_uses_rm = 1'b0; bus.ex_memRead = 1'b0;
    bus.ex_rd = '0; bus.ex_br_taken = 1'b0; bus.mem_access = 1'b0; bus.dmem_ack = 1'b0;

    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle();

    // Load-use on Rn, then on Rm
    drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
    idle();
    drive(1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 5'd3, 5'd4, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    // Taken branch followed by wrong-path flush
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    // Memory wait with ack three cycles later
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    idle();
    // Branch together with load-use
    drive(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    idle();
    // Load into XZR never stalls
    drive(1'b0, 5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0);
    // Reset in the middle of a memory wait
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    idle();

    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 299) == 0), randReg(), randReg(), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) != 0), randReg(), ($urandom_range(0, 5) == 0),
            memPending ? 1'b1 : ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
    end

    for (int i = 0; i < 20 && sbQ.size() > 0; i++) @(negedge clk);
    #1;
    nCompared++;
    if (sbQ.size() != 0) begin
      nMismatch++;
      $display("FAIL drain: %0d entries left, expected 0", sbQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
